fifo_drain_arbiter: RTL and testbench



---
 rtl/fifo_drain_arbiter.sv | 167 ++++++++++++++++
 tb/tb_fifo_drain_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_drain_arbiter
//
// Round-robin scheduler that drains the read sides of NUM_CH show-ahead CDC
// FIFOs sharing one read clock, merging them onto a single valid/ready stream
// tagged with the source channel. One channel is granted at a time for a burst
// of up to MAX_BURST words; arbitration costs one idle cycle per grant.
//
// Optional feature (compile-time macro FIFO_ARB_ALMOST_FULL_PRIO_EN):
//   adds fifo_almost_full_i; non-empty almost-full channels are preferred
//   in arbitration. Without the macro the port is absent and arbitration is
//   pure round-robin over non-empty channels.
//
// Ports:
//   clk                 read-domain clock (shared with all FIFO rd_clk)
//   reset               asynchronous, active-high reset
//   enable_i            arbitration enable; 0 stops grants and pops
//   fifo_empty_i        per-channel FIFO empty flag
//   fifo_almost_full_i  per-channel almost-full flag (macro builds only)
//   fifo_data_i         per-channel show-ahead data, channel k at [k*DSIZE +: DSIZE]
//   fifo_rd_req_o       per-channel pop strobe (combinational, one-hot or zero)
//   m_valid_o           output word valid
//   m_ready_i           downstream ready
//   m_data_o            output word
//   m_ch_o              source channel of m_data_o
//   m_last_o            word is the MAX_BURST-th word of its grant
//   busy_o              a burst is in progress
// -----------------------------------------------------------------------------
module fifo_drain_arbiter #(
  parameter  int NUM_CH    = 4,
  parameter  int DSIZE     = 16,
  parameter  int MAX_BURST = 8,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable_i,
  input  logic [NUM_CH-1:0]       fifo_empty_i,
`ifdef FIFO_ARB_ALMOST_FULL_PRIO_EN
  input  logic [NUM_CH-1:0]       fifo_almost_full_i,
`endif
  input  logic [NUM_CH*DSIZE-1:0] fifo_data_i,
  output logic [NUM_CH-1:0]       fifo_rd_req_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [DSIZE-1:0]        m_data_o,
  output logic [CH_W-1:0]         m_ch_o,
  output logic                    m_last_o,
  output logic                    busy_o
);

  // Counter must hold MAX_BURST after the final pop of a full burst.
  localparam int               CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
  localparam logic [CH_W-1:0]  PTR_RST  = CH_W'(NUM_CH - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_q, state_d;
  // rr_ptr doubles as the current grant: it is set to the granted channel on
  // every grant and stays put for the whole burst.
  logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [DSIZE-1:0]  ch_data [NUM_CH];
  logic [NUM_CH-1:0] cand;
  logic [CH_W-1:0]   rr_idx;
  logic [CH_W-1:0]   pick;
  logic              found;
  logic              pop;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ch_data[k] = fifo_data_i[k*DSIZE +: DSIZE];
    end
  end

  // Candidate set for the next grant.
`ifdef FIFO_ARB_ALMOST_FULL_PRIO_EN
  logic [NUM_CH-1:0] urgent;
  assign urgent = ~fifo_empty_i & fifo_almost_full_i;
  assign cand   = (|urgent) ? urgent : ~fifo_empty_i;
`else
  assign cand   = ~fifo_empty_i;
`endif

  // First candidate searching upward from rr_ptr+1, wrapping at NUM_CH.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    rr_idx = rr_ptr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      rr_idx = (rr_idx == PTR_RST) ? '0 : rr_idx + 1'b1;
      if (!found && cand[rr_idx]) begin
        found = 1'b1;
        pick  = rr_idx;
      end
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    count_d       = count_q;
    pop           = 1'b0;
    fifo_rd_req_o = '0;
    case (state_q)
      IDLE: begin
        // Grant only; the first pop happens in BURST on the next cycle.
        if (enable_i && found) begin
          state_d  = BURST;
          rr_ptr_d = pick;
          count_d  = '0;
        end
      end
      BURST: begin
        // Pop when data is present and the output register is free or
        // being emptied this cycle.
        pop = !fifo_empty_i[rr_ptr_q] && enable_i && (!m_valid_o || m_ready_i);
        if (pop) begin
          fifo_rd_req_o[rr_ptr_q] = 1'b1;
          count_d                 = count_q + 1'b1;
        end
        if ((pop && count_q == LAST_CNT) || fifo_empty_i[rr_ptr_q] || !enable_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments for every flop, so all registers sample the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= PTR_RST;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Output register: reload on pop, clear on accept, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_ch_o    <= '0;
      m_last_o  <= 1'b0;
    end else if (pop) begin
      m_valid_o <= 1'b1;
      m_data_o  <= ch_data[rr_ptr_q];
      m_ch_o    <= rr_ptr_q;
      m_last_o  <= (count_q == LAST_CNT);
    end else if (m_ready_i) begin
      m_valid_o <= 1'b0;
    end
  end

  assign busy_o = (state_q == BURST);

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_drain_arbiter
//
// Self-checking bench for fifo_drain_arbiter. Per-channel FIFOs are modelled
// as queues (show-ahead, empty flag updates the cycle after a pop). Expected
// output words come from a grant-level model: channels are served round-robin
// from the last granted channel, each grant taking min(MAX_BURST, words left),
// with the MAX_BURST-th word of a grant flagged last.
// -----------------------------------------------------------------------------
module tb_fifo_drain_arbiter;

  localparam int NUM_CH    = 4;
  localparam int DSIZE     = 16;
  localparam int MAX_BURST = 8;
  localparam int CH_W      = $clog2(NUM_CH);

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    enable_i;
  logic [NUM_CH-1:0]       fifo_empty_i;
`ifdef FIFO_ARB_ALMOST_FULL_PRIO_EN
  logic [NUM_CH-1:0]       fifo_almost_full_i;
`endif
  logic [NUM_CH*DSIZE-1:0] fifo_data_i;
  logic [NUM_CH-1:0]       fifo_rd_req_o;
  logic                    m_valid_o;
  logic                    m_ready_i;
  logic [DSIZE-1:0]        m_data_o;
  logic [CH_W-1:0]         m_ch_o;
  logic                    m_last_o;
  logic                    busy_o;

  fifo_drain_arbiter #(
    .NUM_CH    (NUM_CH),
    .DSIZE     (DSIZE),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .enable_i           (enable_i),
    .fifo_empty_i       (fifo_empty_i),
`ifdef FIFO_ARB_ALMOST_FULL_PRIO_EN
    .fifo_almost_full_i (fifo_almost_full_i),
`endif
    .fifo_data_i        (fifo_data_i),
    .fifo_rd_req_o      (fifo_rd_req_o),
    .m_valid_o          (m_valid_o),
    .m_ready_i          (m_ready_i),
    .m_data_o           (m_data_o),
    .m_ch_o             (m_ch_o),
    .m_last_o           (m_last_o),
    .busy_o             (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [DSIZE-1:0] data;
    logic             last;
  } word_t;

  logic [DSIZE-1:0] fq [NUM_CH][$];  // FIFO contents presented to the DUT
  logic [DSIZE-1:0] mq [NUM_CH][$];  // words not yet assigned to a modelled grant
  word_t            exp_q[$];
  int               model_ptr;

  int               n_cmp, n_err, cyc;
  int               pop_cnt [NUM_CH];
  int               first_pop, last_pop;
  logic [NUM_CH-1:0] pending;
  logic             hold_v, hold_last;
  logic [DSIZE-1:0] hold_data;
  logic [CH_W-1:0]  hold_ch;
  int               ready_mode;  // 0: always 1, 1: toggle, 2: random, 3: hold

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic drive_fifos();
    for (int k = 0; k < NUM_CH; k++) begin
      fifo_empty_i[k]                = (fq[k].size() == 0);
      fifo_data_i[k*DSIZE +: DSIZE]  = (fq[k].size() != 0) ? fq[k][0] : '0;
    end
  endtask

  task automatic load(input int ch, input int n);
    logic [DSIZE-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = DSIZE'($urandom);
      fq[ch].push_back(d);
      mq[ch].push_back(d);
    end
    drive_fifos();
  endtask

  // One modelled grant of n words from channel ch.
  task automatic push_grant(input int ch, input int n);
    word_t w;
    for (int j = 0; j < n; j++) begin
      w.ch   = CH_W'(ch);
      w.data = mq[ch].pop_front();
      w.last = (j == MAX_BURST - 1);
      exp_q.push_back(w);
    end
    model_ptr = ch;
  endtask

  // Round-robin over remaining words until every channel is exhausted.
  task automatic run_rr(output int grants);
    bit any;
    grants = 0;
    do begin
      any = 0;
      for (int i = 1; i <= NUM_CH; i++) begin
        int c;
        c = (model_ptr + i) % NUM_CH;
        if (mq[c].size() != 0) begin
          push_grant(c, (mq[c].size() < MAX_BURST) ? mq[c].size() : MAX_BURST);
          grants++;
          any = 1;
          break;
        end
      end
    end while (any);
  endtask

  task automatic clear_stats();
    foreach (pop_cnt[k]) pop_cnt[k] = 0;
    first_pop = -1;
    last_pop  = -1;
  endtask

  // One clock: observe at negedge, apply pops and new stimulus after posedge.
  task automatic tick();
    word_t w;
    @(negedge clk);
    cyc++;
    check("req_onehot", $onehot0(fifo_rd_req_o), 1);
    for (int k = 0; k < NUM_CH; k++) begin
      if (fifo_rd_req_o[k]) begin
        check($sformatf("req_nonempty_ch%0d", k), fq[k].size() != 0, 1);
        check("req_in_burst", busy_o, 1);
        pop_cnt[k]++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
    if (hold_v) begin
      check("hold_valid", m_valid_o, 1);
      check("hold_data", m_data_o, hold_data);
      check("hold_ch", m_ch_o, hold_ch);
      check("hold_last", m_last_o, hold_last);
    end
    if (m_valid_o && m_ready_i) begin
      check("word_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("word_ch", m_ch_o, w.ch);
        check("word_data", m_data_o, w.data);
        check("word_last", m_last_o, w.last);
      end
    end
    hold_v    = m_valid_o && !m_ready_i;
    hold_data = m_data_o;
    hold_ch   = m_ch_o;
    hold_last = m_last_o;
    pending   = fifo_rd_req_o;
    @(posedge clk);
    #1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (pending[k] && fq[k].size() != 0) void'(fq[k].pop_front());
    end
    drive_fifos();
    case (ready_mode)
      0:       m_ready_i = 1'b1;
      1:       m_ready_i = !m_ready_i;
      2:       m_ready_i = ($urandom_range(0, 99) < 65);
      default: m_ready_i = m_ready_i;
    endcase
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid_o || busy_o) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_in_time"}, n < budget, 1);
    check({tag, "_all_words"}, exp_q.size(), 0);
    check({tag, "_fifos_empty"}, fifo_empty_i, {NUM_CH{1'b1}});
  endtask

  task automatic reset_dut();
    reset     = 1'b1;
    hold_v    = 1'b0;
    model_ptr = NUM_CH - 1;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_req"}, fifo_rd_req_o, 0);
    check({tag, "_valid"}, m_valid_o, 0);
    check({tag, "_data"}, m_data_o, 0);
    check({tag, "_ch"}, m_ch_o, 0);
    check({tag, "_last"}, m_last_o, 0);
    check({tag, "_busy"}, busy_o, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, n, total, pops_before;
    n_cmp      = 0;
    n_err      = 0;
    cyc        = 0;
    hold_v     = 1'b0;
    ready_mode = 0;
    model_ptr  = NUM_CH - 1;
    reset      = 1'b1;
    enable_i   = 1'b1;
    m_ready_i  = 1'b1;
`ifdef FIFO_ARB_ALMOST_FULL_PRIO_EN
    fifo_almost_full_i = '0;
`endif
    clear_stats();
    drive_fifos();

    // Reset state.
    #1;
    check_outputs_zero("reset");
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("idle_when_empty", busy_o, 0);

    // ch0 holds 20 words: bursts 8, 8, 4 with one idle cycle between grants.
    clear_stats();
    load(0, 20);
    run_rr(g);
    drain("ch0_20", 200);
    check("ch0_20_span", last_pop - first_pop + 1, 20 + g - 1);
    check("ch0_20_pops", pop_cnt[0], 20);

    // All four channels hold 8 words: order 0..3, back-to-back bursts.
    reset_dut();
    clear_stats();
    for (int k = 0; k < NUM_CH; k++) load(k, 8);
    run_rr(g);
    drain("all8", 300);
    check("all8_span", last_pop - first_pop + 1, 32 + g - 1);
    total = 0;
    foreach (pop_cnt[k]) total += pop_cnt[k];
    check("all8_pops", total, 32);

    // ch2 holds 3 words with ready toggling every cycle.
    reset_dut();
    clear_stats();
    ready_mode = 1;
    load(2, 3);
    run_rr(g);
    drain("toggle", 100);
    check("toggle_pops_ch2", pop_cnt[2], 3);

    // Disable after the third pop of ch1; ch2 must be served before ch1 again.
    reset_dut();
    clear_stats();
    ready_mode = 0;
    m_ready_i  = 1'b1;
    load(1, 8);
    load(2, 4);
    push_grant(1, 3);
    n = 0;
    while (pop_cnt[1] < 3 && n < 30) begin
      tick();
      n++;
    end
    check("dis_three_pops", pop_cnt[1], 3);
    enable_i    = 1'b0;
    pops_before = pop_cnt[0] + pop_cnt[1] + pop_cnt[2] + pop_cnt[3];
    repeat (6) tick();
    check("dis_no_pops", pop_cnt[0] + pop_cnt[1] + pop_cnt[2] + pop_cnt[3], pops_before);
    check("dis_idle", busy_o, 0);
    check("dis_drained_valid", m_valid_o, 0);
    check("dis_drained_word", exp_q.size(), 0);
    enable_i = 1'b1;
    run_rr(g);
    drain("reenable", 200);

    // Reset while a word is waiting in the output register.
    reset_dut();
    ready_mode = 3;
    m_ready_i  = 1'b0;
    load(1, 8);
    load(3, 8);
    n = 0;
    while (!m_valid_o && n < 20) begin
      tick();
      n++;
    end
    check("rst_mid_valid_seen", m_valid_o, 1);
    reset  = 1'b1;
    hold_v = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    void'(mq[1].pop_front());  // the dropped in-flight word
    model_ptr = NUM_CH - 1;
    exp_q.delete();
    tick();
    tick();
    reset      = 1'b0;
    ready_mode = 2;
    run_rr(g);
    drain("after_rst", 300);

`ifdef FIFO_ARB_ALMOST_FULL_PRIO_EN
    // Almost-full ch3 outranks ch0 even though ch0 is next in rotation.
    reset_dut();
    ready_mode         = 0;
    m_ready_i          = 1'b1;
    fifo_almost_full_i = 4'b1000;
    load(0, 4);
    load(3, 4);
    push_grant(3, 4);
    push_grant(0, 4);
    drain("af_prio", 100);
    fifo_almost_full_i = '0;
`endif

    // Random fills, random backpressure, pointer carried across rounds.
    ready_mode = 2;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NUM_CH; k++) load(k, $urandom_range(0, 20));
      run_rr(g);
      drain($sformatf("rand%0d", r), 2000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
